// File: rtl/split2_pkg.sv
// Shared types and helpers for the two-way split distributor.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package split2_pkg;

   // Buffer either accepts a whole vector or drains it; never both.
   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } split_state_t;

   // Element counters must be able to hold the value 'total'.
   function automatic int idx_width(input int total);
      return $clog2(total + 1);
   endfunction

endpackage

// File: rtl/split2_rd_port.sv
// Per-part read cursor: tracks element index and done flag for one output port.
// Latency: valid is combinational from state/done; index advances on the accepted beat.
// Backpressure: holds the current beat until rd_en; rd_en without valid is ignored.
module split2_rd_port
   import split2_pkg::*;
#(
   parameter int BASE = 0,
   parameter int VEC  = 8,
   parameter int EPR  = 2,
   parameter int IW   = idx_width(16)
) (
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic          drain,
   input  logic          rd_en,
   input  logic          clear,
   output logic          valid,
   output logic          last_beat,
   output logic          done,
   output logic [IW-1:0] rd_addr
);

   logic [IW-1:0] rd_idx_q;
   logic          done_q;

   assign valid     = drain & ~done_q;
   assign last_beat = valid & rd_en & (rd_idx_q == IW'(VEC - EPR));
   assign done      = done_q;
   // Absolute storage address of the first element of the current beat.
   assign rd_addr   = rd_idx_q + IW'(BASE);

   // Advance the cursor on each accepted beat; park at done until the parent clears.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         rd_idx_q <= '0;
         done_q   <= 1'b0;
      end else if (clear) begin
         rd_idx_q <= '0;
         done_q   <= 1'b0;
      end else if (valid && rd_en) begin
         if (last_beat) begin
            rd_idx_q <= '0;
            done_q   <= 1'b1;
         end else begin
            rd_idx_q <= rd_idx_q + IW'(EPR);
         end
      end
   end

endmodule

// File: rtl/split2_fifo_distributor.sv
// Buffers one concatenated vector, then streams part0/part1 on two independent ports.
// Latency: both read ports valid the cycle after the final write beat.
// Backpressure: wr_ready low while draining (drops + wr_err; sticky if SPLIT2_STICKY_ERR_EN).
module split2_fifo_distributor
   import split2_pkg::*;
#(
   parameter int NBits            = 16,
   parameter int VecElements0     = 8,
   parameter int VecElements1     = 8,
   parameter int ElementsPerWrite = 2,
   parameter int ElementsPerRead0 = 2,
   parameter int ElementsPerRead1 = 4
) (
   input  logic                                        clk_in,
   input  logic                                        rst_in,
   input  logic                                        wr_en,
   input  logic [ElementsPerWrite-1:0][NBits-1:0]      wr_data,
   output logic                                        wr_ready,
   input  logic                                        rd_en0,
   output logic [ElementsPerRead0-1:0][NBits-1:0]      rd_data0,
   output logic                                        rd_valid0,
   input  logic                                        rd_en1,
   output logic [ElementsPerRead1-1:0][NBits-1:0]      rd_data1,
   output logic                                        rd_valid1,
   output logic                                        wr_err
);

   localparam int TOTAL = VecElements0 + VecElements1;
   localparam int IW    = idx_width(TOTAL);
   localparam int AW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

   split_state_t   state_q, state_d;
   logic [IW-1:0]  wr_idx_q;
   logic [NBits-1:0] mem [TOTAL];

   logic          wr_fire, wr_last, wr_drop;
   logic          drain;
   logic          last0, last1, done0, done1, both_done, clear;
   logic [IW-1:0] addr0, addr1;
   logic          wr_err_q;

   assign drain    = (state_q == DRAIN);
   assign wr_ready = (state_q == FILL);
   assign wr_fire  = wr_en & wr_ready;
   assign wr_drop  = wr_en & ~wr_ready;
   assign wr_last  = wr_fire & (wr_idx_q == IW'(TOTAL - ElementsPerWrite));

   // Both parts finished, counting a final beat accepted this very cycle.
   assign both_done = (done0 | last0) & (done1 | last1);
   assign clear     = drain & both_done;
   assign wr_err    = wr_err_q;

   split2_rd_port #(
      .BASE (0),
      .VEC  (VecElements0),
      .EPR  (ElementsPerRead0),
      .IW   (IW)
   ) u_port0 (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .drain     (drain),
      .rd_en     (rd_en0),
      .clear     (clear),
      .valid     (rd_valid0),
      .last_beat (last0),
      .done      (done0),
      .rd_addr   (addr0)
   );

   split2_rd_port #(
      .BASE (VecElements0),
      .VEC  (VecElements1),
      .EPR  (ElementsPerRead1),
      .IW   (IW)
   ) u_port1 (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .drain     (drain),
      .rd_en     (rd_en1),
      .clear     (clear),
      .valid     (rd_valid1),
      .last_beat (last1),
      .done      (done1),
      .rd_addr   (addr1)
   );

   // State register.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) state_q <= FILL;
      else         state_q <= state_d;
   end

   // Next state: fill until the last element lands, drain until both parts are done.
   always_comb begin
      state_d = state_q;
      case (state_q)
         FILL:    if (wr_last)   state_d = DRAIN;
         DRAIN:   if (both_done) state_d = FILL;
         default: state_d = FILL;
      endcase
   end

   // Write cursor in elements; wraps to zero on the beat that completes the vector.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in)      wr_idx_q <= '0;
      else if (wr_last) wr_idx_q <= '0;
      else if (wr_fire) wr_idx_q <= wr_idx_q + IW'(ElementsPerWrite);
   end

   // Element storage; contents are don't-care until fully written, so no reset.
   always_ff @(posedge clk_in) begin
      if (wr_fire) begin
         for (int i = 0; i < ElementsPerWrite; i++)
            mem[AW'(wr_idx_q + IW'(i))] <= wr_data[i];
      end
   end

   // Dropped-write flag: sticky latch or single-cycle pulse.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) wr_err_q <= 1'b0;
`ifdef SPLIT2_STICKY_ERR_EN
      else         wr_err_q <= wr_err_q | wr_drop;
`else
      else         wr_err_q <= wr_drop;
`endif
   end

   // Part0 read mux; zero whenever the port has nothing to offer.
   always_comb begin
      rd_data0 = '0;
      if (rd_valid0) begin
         for (int i = 0; i < ElementsPerRead0; i++)
            rd_data0[i] = mem[AW'(addr0 + IW'(i))];
      end
   end

   // Part1 read mux; zero whenever the port has nothing to offer.
   always_comb begin
      rd_data1 = '0;
      if (rd_valid1) begin
         for (int i = 0; i < ElementsPerRead1; i++)
            rd_data1[i] = mem[AW'(addr1 + IW'(i))];
      end
   end

endmodule

// File: tb/tb_split2_fifo_distributor.sv
// Bench for the split distributor: scoreboard of expected read beats per port.
// Latency: checks valid one cycle after the final write beat.
// Backpressure: exercises dropped writes, idle reads and mid-fill reset.
module tb_split2_fifo_distributor;

   logic                 clk_in = 1'b0;
   logic                 rst_in;
   logic                 wr_en;
   logic [1:0][15:0]     wr_data;
   logic                 wr_ready;
   logic                 rd_en0, rd_en1;
   logic [1:0][15:0]     rd_data0;
   logic [3:0][15:0]     rd_data1;
   logic                 rd_valid0, rd_valid1;
   logic                 wr_err;

   logic [63:0] q0[$];
   logic [63:0] q1[$];
   int n_pass = 0;
   int n_total = 0;
   logic [63:0] head;

`ifdef SPLIT2_STICKY_ERR_EN
   localparam logic STICKY = 1'b1;
`else
   localparam logic STICKY = 1'b0;
`endif

   always #5 clk_in = ~clk_in;

   split2_fifo_distributor dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .wr_ready  (wr_ready),
      .rd_en0    (rd_en0),
      .rd_data0  (rd_data0),
      .rd_valid0 (rd_valid0),
      .rd_en1    (rd_en1),
      .rd_data1  (rd_data1),
      .rd_valid1 (rd_valid1),
      .wr_err    (wr_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
   endtask

   // Write nbeats beats of elements base+idx; a full vector pushes expected read beats.
   task automatic write_vec(input int base, input int nbeats);
      logic [63:0] e;
      for (int b = 0; b < nbeats; b++) begin
         chk("wr_ready_fill", {63'b0, wr_ready}, 64'd1);
         wr_en = 1'b1;
         for (int k = 0; k < 2; k++) wr_data[k] = 16'(base + 2*b + k);
         @(negedge clk_in);
      end
      wr_en   = 1'b0;
      wr_data = '0;
      if (nbeats == 8) begin
         for (int k = 0; k < 4; k++) begin
            e = '0;
            for (int j = 0; j < 2; j++) e[j*16 +: 16] = 16'(base + 2*k + j);
            q0.push_back(e);
         end
         for (int k = 0; k < 2; k++) begin
            e = '0;
            for (int j = 0; j < 4; j++) e[j*16 +: 16] = 16'(base + 8 + 4*k + j);
            q1.push_back(e);
         end
      end
   endtask

   // One read cycle: check each requested port against the scoreboard head, then consume.
   task automatic drain_cycle(input logic e0, input logic e1);
      if (e0) begin
         chk("rd_valid0", {63'b0, rd_valid0}, 64'd1);
         if (q0.size() == 0) chk("q0_underflow", 64'd1, 64'd0);
         else begin head = q0.pop_front(); chk("rd_data0", {32'b0, rd_data0}, head); end
      end
      if (e1) begin
         chk("rd_valid1", {63'b0, rd_valid1}, 64'd1);
         if (q1.size() == 0) chk("q1_underflow", 64'd1, 64'd0);
         else begin head = q1.pop_front(); chk("rd_data1", rd_data1, head); end
      end
      rd_en0 = e0;
      rd_en1 = e1;
      @(negedge clk_in);
      rd_en0 = 1'b0;
      rd_en1 = 1'b0;
   endtask

   task automatic chk_idle(input string tag, input logic exp_err);
      chk({tag, "_wr_ready"}, {63'b0, wr_ready}, 64'd1);
      chk({tag, "_valid0"},   {63'b0, rd_valid0}, 64'd0);
      chk({tag, "_valid1"},   {63'b0, rd_valid1}, 64'd0);
      chk({tag, "_data0"},    {32'b0, rd_data0}, 64'd0);
      chk({tag, "_data1"},    rd_data1, 64'd0);
      chk({tag, "_wr_err"},   {63'b0, wr_err}, {63'b0, exp_err});
   endtask

   initial begin
      rst_in  = 1'b0;
      wr_en   = 1'b0;
      wr_data = '0;
      rd_en0  = 1'b0;
      rd_en1  = 1'b0;
      repeat (2) @(negedge clk_in);
      chk_idle("reset", 1'b0);
      rst_in = 1'b1;
      @(negedge clk_in);

      // Fill with 0..15, both ports valid next cycle, then drain with final beats together.
      write_vec(0, 8);
      chk("fill_valid0", {63'b0, rd_valid0}, 64'd1);
      chk("fill_valid1", {63'b0, rd_valid1}, 64'd1);
      chk("fill_wr_ready", {63'b0, wr_ready}, 64'd0);
      drain_cycle(1'b1, 1'b0);
      drain_cycle(1'b1, 1'b0);
      drain_cycle(1'b1, 1'b1);
      drain_cycle(1'b1, 1'b1);
      chk_idle("drained", 1'b0);

      // Part1 first; idle read on part1; dropped write while draining.
      write_vec(100, 8);
      drain_cycle(1'b0, 1'b1);
      drain_cycle(1'b0, 1'b1);
      chk("p1done_valid1", {63'b0, rd_valid1}, 64'd0);
      chk("p1done_valid0", {63'b0, rd_valid0}, 64'd1);
      chk("p1done_wr_ready", {63'b0, wr_ready}, 64'd0);
      chk("p1done_data1", rd_data1, 64'd0);
      rd_en1 = 1'b1;
      @(negedge clk_in);
      rd_en1 = 1'b0;
      chk("idle_rd_valid1", {63'b0, rd_valid1}, 64'd0);
      chk("idle_rd_valid0", {63'b0, rd_valid0}, 64'd1);
      chk("idle_rd_data0", {32'b0, rd_data0}, q0[0]);
      wr_en   = 1'b1;
      wr_data = {16'hDEAD, 16'hDEAD};
      @(negedge clk_in);
      wr_en   = 1'b0;
      wr_data = '0;
      chk("drop_wr_err", {63'b0, wr_err}, 64'd1);
      chk("drop_rd_data0", {32'b0, rd_data0}, q0[0]);
      chk("drop_wr_ready", {63'b0, wr_ready}, 64'd0);
      @(negedge clk_in);
      chk("drop_wr_err_after", {63'b0, wr_err}, {63'b0, STICKY});
      drain_cycle(1'b1, 1'b0);
      drain_cycle(1'b1, 1'b0);
      drain_cycle(1'b1, 1'b0);
      chk("p0_pending_wr_ready", {63'b0, wr_ready}, 64'd0);
      drain_cycle(1'b1, 1'b0);
      chk_idle("drained2", STICKY);

      // Partial fill then reset: a fresh vector must read back without stale data.
      write_vec(200, 3);
      rst_in = 1'b0;
      #2;
      chk_idle("midfill_reset", 1'b0);
      @(negedge clk_in);
      rst_in = 1'b1;
      @(negedge clk_in);
      write_vec(300, 8);
      drain_cycle(1'b1, 1'b0);
      drain_cycle(1'b1, 1'b1);
      drain_cycle(1'b1, 1'b0);
      drain_cycle(1'b1, 1'b1);
      chk_idle("drained3", 1'b0);
      chk("q0_empty", 64'(q0.size()), 64'd0);
      chk("q1_empty", 64'(q1.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
